// File: rtl/hu_audiodec_dma64_rd_unpack.sv
// Read-side DMA front end for the audio decoder: issues one DMA read per request
// and unpacks 64-bit beats into an in-order 32-bit valid/ready word stream.
module hu_audiodec_dma64_rd_unpack #(
  parameter logic [2:0] DMA_SIZE = 3'b010,
  parameter bit         HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_index,
  input  logic [31:0] req_length,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [63:0] dma_read_chnl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CTRL,
    S_DATA,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   index_q;
  logic [WORD_W-1:0]   length_q;
  logic [WORD_W-1:0]   words_left_q;
  logic [WORD_W-1:0]   beats_left_q;
  logic [BEAT_W-1:0]   hold_q;
  logic                hold_v_q;
  logic                half_q;

  logic                out_fire_c;
  logic                beat_fire_c;
  logic                sel_hi_c;

  // Status and control outputs decode directly from the state register.
  assign req_ready                 = (state_q == S_IDLE);
  assign dma_read_ctrl_valid       = (state_q == S_CTRL);
  assign dma_read_ctrl_data_index  = index_q;
  assign dma_read_ctrl_data_length = length_q;
  assign dma_read_ctrl_data_size   = DMA_SIZE;
  assign done                      = (state_q == S_DONE);
  assign busy                      = (state_q != S_IDLE);

  assign out_valid  = hold_v_q;
  assign out_fire_c = hold_v_q && out_ready;

  // A new beat may refill the holder in the same cycle its second word drains.
  assign dma_read_chnl_ready = (state_q == S_DATA)
                             && (!hold_v_q || (out_fire_c && half_q))
                             && (beats_left_q != '0);
  assign beat_fire_c = dma_read_chnl_valid && dma_read_chnl_ready;

  assign sel_hi_c = half_q ^ HI_FIRST;
  assign out_data = sel_hi_c ? hold_q[BEAT_W-1:WORD_W] : hold_q[WORD_W-1:0];
  assign out_last = hold_v_q && (words_left_q == WORD_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      length_q     <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      half_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            index_q      <= req_index;
            length_q     <= req_length;
            words_left_q <= req_length;
            beats_left_q <= (req_length >> 1) + WORD_W'(req_length[0]);
            state_q      <= (req_length == '0) ? S_DONE : S_CTRL;
          end
        end
        S_CTRL: begin
          if (dma_read_ctrl_ready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          // Output side first; a same-cycle beat load below overrides hold_v/half.
          if (out_fire_c) begin
            words_left_q <= words_left_q - WORD_W'(1);
            if (!half_q && (words_left_q > WORD_W'(1))) begin
              half_q <= 1'b1;
            end else begin
              hold_v_q <= 1'b0;
            end
            if (words_left_q == WORD_W'(1)) begin
              state_q <= S_DONE;
            end
          end
          if (beat_fire_c) begin
            hold_q       <= dma_read_chnl_data;
            hold_v_q     <= 1'b1;
            half_q       <= 1'b0;
            beats_left_q <= beats_left_q - WORD_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
